// File: rtl/neurotransmitter_level_integrator.sv
// Prescaled integrator of regulator inc/dec requests into an 8-bit concentration,
// with saturation, idle drift toward baseline and a hysteretic 2-bit level.
module neurotransmitter_level_integrator #(
  parameter int PRESCALE    = 8,
  parameter int STEP_SLOW   = 1,
  parameter int STEP_FAST   = 4,
  parameter int RESET_LEVEL = 128,
  parameter int DRIFT_TICKS = 16,
  parameter int HYST        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       inc,
  input  logic       dec,
  input  logic       fast,
  output logic [1:0] level,
  output logic [7:0] level_raw,
  output logic       at_max,
  output logic       at_min,
  output logic       tick
);
  // level state | meaning
  // 2'b00       | low band       (raw below ~64)
  // 2'b01       | mid-low band   (raw ~64..127)
  // 2'b10       | mid-high band  (raw ~128..191)
  // 2'b11       | high band      (raw ~192 and above)

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(DRIFT_TICKS - 1);
  localparam logic [7:0] BASE       = 8'(RESET_LEVEL);
  localparam logic [1:0] BASE_LVL   = BASE[7:6];
  localparam logic [8:0] STEP_S     = 9'(STEP_SLOW);
  localparam logic [8:0] STEP_F     = 9'(STEP_FAST);
  localparam logic [9:0] HYST_W     = 10'(HYST);

  logic [7:0] presc_q;
  logic [7:0] idle_q;
  logic [7:0] idle_nxt;
  logic [7:0] raw_q;
  logic [7:0] raw_nxt;
  logic [1:0] lvl_q;
  logic [1:0] lvl_nxt;
  logic       tick_q;
  logic       upd;
  logic [8:0] step;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [9:0] up_thr;
  logic [9:0] dn_thr;

  assign upd = ena && (presc_q == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= 8'd0;
      idle_q  <= 8'd0;
      raw_q   <= BASE;
      lvl_q   <= BASE_LVL;
      tick_q  <= 1'b0;
    end else if (ena) begin
      presc_q <= upd ? 8'd0 : presc_q + 8'd1;
      tick_q  <= upd;
      if (upd) begin
        raw_q  <= raw_nxt;
        idle_q <= idle_nxt;
        lvl_q  <= lvl_nxt;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  // 9-bit arithmetic: bit 8 flags overflow on add and borrow on subtract
  always_comb begin
    step     = fast ? STEP_F : STEP_S;
    sum9     = {1'b0, raw_q} + step;
    diff9    = {1'b0, raw_q} - step;
    raw_nxt  = raw_q;
    idle_nxt = idle_q;
    if (inc && !dec) begin
      raw_nxt  = sum9[8] ? 8'hFF : sum9[7:0];
      idle_nxt = 8'd0;
    end else if (dec && !inc) begin
      raw_nxt  = diff9[8] ? 8'h00 : diff9[7:0];
      idle_nxt = 8'd0;
    end else if (idle_q == IDLE_LAST) begin
      idle_nxt = 8'd0;
      if (raw_q < BASE) begin
        raw_nxt = raw_q + 8'd1;
      end else if (raw_q > BASE) begin
        raw_nxt = raw_q - 8'd1;
      end
    end else begin
      idle_nxt = idle_q + 8'd1;
    end
  end

  // band thresholds are judged against the value raw is about to take
  always_comb begin
    up_thr  = {2'b00, lvl_q, 6'd0} + 10'd64 + HYST_W;
    dn_thr  = {2'b00, lvl_q, 6'd0} - HYST_W;
    lvl_nxt = lvl_q;
    if (lvl_q != 2'd3 && {2'b00, raw_nxt} >= up_thr) begin
      lvl_nxt = lvl_q + 2'd1;
    end else if (lvl_q != 2'd0 && {2'b00, raw_nxt} < dn_thr) begin
      lvl_nxt = lvl_q - 2'd1;
    end
  end

  always_comb begin
    level     = lvl_q;
    level_raw = raw_q;
    at_max    = (raw_q == 8'hFF);
    at_min    = (raw_q == 8'h00);
    tick      = tick_q;
  end

endmodule

// File: tb/tb_neurotransmitter_level_integrator.sv
// Directed bench for neurotransmitter_level_integrator: a behavioural model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_neurotransmitter_level_integrator;
  localparam int PRESCALE    = 8;
  localparam int STEP_SLOW   = 1;
  localparam int STEP_FAST   = 4;
  localparam int RESET_LEVEL = 128;
  localparam int DRIFT_TICKS = 16;
  localparam int HYST        = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       fast = 1'b0;
  logic [1:0] level;
  logic [7:0] level_raw;
  logic       at_max;
  logic       at_min;
  logic       tick;

  int tests_run    = 0;
  int tests_failed = 0;
  bit checking     = 1'b0;

  // model state: enabled-cycle count since the last update, value, band, idle ticks
  int m_phase = 0;
  int m_raw   = RESET_LEVEL;
  int m_lvl   = RESET_LEVEL / 64;
  int m_idle  = 0;
  int m_tick  = 0;

  neurotransmitter_level_integrator #(
    .PRESCALE(PRESCALE), .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST),
    .RESET_LEVEL(RESET_LEVEL), .DRIFT_TICKS(DRIFT_TICKS), .HYST(HYST)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .inc(inc), .dec(dec), .fast(fast),
    .level(level), .level_raw(level_raw), .at_max(at_max), .at_min(at_min),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      if (tests_failed <= 40)
        $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int s;
    s = fast ? STEP_FAST : STEP_SLOW;
    if (inc && !dec) begin
      m_raw  = (m_raw + s > 255) ? 255 : m_raw + s;
      m_idle = 0;
    end else if (dec && !inc) begin
      m_raw  = (m_raw - s < 0) ? 0 : m_raw - s;
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == DRIFT_TICKS) begin
        m_idle = 0;
        if (m_raw < RESET_LEVEL) m_raw++;
        else if (m_raw > RESET_LEVEL) m_raw--;
      end
    end
    if (m_lvl < 3 && m_raw >= 64 * (m_lvl + 1) + HYST) m_lvl++;
    else if (m_lvl > 0 && m_raw < 64 * m_lvl - HYST) m_lvl--;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_raw = RESET_LEVEL; m_lvl = RESET_LEVEL / 64;
      m_idle = 0; m_tick = 0;
    end else if (!ena) begin
      m_tick = 0;
    end else begin
      m_phase++;
      if (m_phase == PRESCALE) begin
        m_phase = 0;
        model_update();
        m_tick = 1;
      end else begin
        m_tick = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("model_raw", int'(level_raw), m_raw);
      check("model_level", int'(level), m_lvl);
      check("model_tick", int'(tick), m_tick);
      check("model_at_max", int'(at_max), int'(m_raw == 255));
      check("model_at_min", int'(at_min), int'(m_raw == 0));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input bit e, input bit i, input bit d, input bit f);
    ena = e; inc = i; dec = d; fast = f;
  endtask

  // one reset cycle, reset state checked, then release with the given inputs
  task automatic do_reset(input bit e, input bit i, input bit d, input bit f);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_raw", int'(level_raw), 128);
    check("rst_level", int'(level), 2);
    check("rst_tick", int'(tick), 0);
    check("rst_at_max", int'(at_max), 0);
    rst = 1'b0;
    set_in(e, i, d, f);
  endtask

  initial begin
    cycles(2);
    checking = 1'b1;

    // slow increments: 8 ticks in 64 cycles
    do_reset(1, 1, 0, 0);
    cycles(7);
    check("s1_no_tick_c7", int'(tick), 0);
    cycles(1);
    check("s1_tick_c8", int'(tick), 1);
    check("s1_raw_c8", int'(level_raw), 129);
    cycles(56);
    check("s1_raw_c64", int'(level_raw), 136);
    check("s1_level_c64", int'(level), 2);

    // fast increments up to saturation
    do_reset(1, 1, 0, 1);
    cycles(128);
    check("s2_raw_t16", int'(level_raw), 192);
    check("s2_level_t16", int'(level), 2);
    cycles(8);
    check("s2_raw_t17", int'(level_raw), 196);
    check("s2_level_t17", int'(level), 3);
    // from 196 / band 3, fast decrements exercise the lower threshold
    set_in(1, 0, 1, 1);
    cycles(8);
    check("s3_raw_192", int'(level_raw), 192);
    check("s3_level_192", int'(level), 3);
    cycles(8);
    check("s3_raw_188", int'(level_raw), 188);
    check("s3_level_188", int'(level), 3);
    cycles(8);
    check("s3_raw_184", int'(level_raw), 184);
    check("s3_level_184", int'(level), 2);

    do_reset(1, 1, 0, 1);
    cycles(256);
    check("s2_raw_t32", int'(level_raw), 255);
    check("s2_at_max_t32", int'(at_max), 1);
    cycles(16);
    check("s2_raw_sat", int'(level_raw), 255);
    check("s2_tick_sat", int'(tick), 1);

    // fast decrements to the floor
    do_reset(1, 0, 1, 1);
    cycles(264);
    check("s7_raw_floor", int'(level_raw), 0);
    check("s7_at_min", int'(at_min), 1);
    check("s7_level_floor", int'(level), 0);

    // idle drift toward baseline
    do_reset(1, 1, 0, 0);
    cycles(64);
    set_in(1, 1, 1, 1);
    cycles(15 * 8);
    check("s4_hold_136", int'(level_raw), 136);
    cycles(8);
    check("s4_drift_135", int'(level_raw), 135);
    set_in(1, 0, 0, 0);
    cycles(16 * 8);
    check("s4_drift_134", int'(level_raw), 134);
    set_in(1, 1, 0, 0);
    cycles(8);
    check("s4_inc_135", int'(level_raw), 135);
    set_in(1, 0, 0, 1);
    cycles(15 * 8);
    check("s4_restart_hold", int'(level_raw), 135);
    cycles(8);
    check("s4_restart_drift", int'(level_raw), 134);

    // enable gating mid-prescale
    do_reset(1, 1, 0, 0);
    cycles(5);
    set_in(0, 1, 0, 0);
    cycles(20);
    check("s5_frozen_raw", int'(level_raw), 128);
    check("s5_frozen_tick", int'(tick), 0);
    set_in(1, 1, 0, 0);
    cycles(2);
    check("s5_no_tick_e2", int'(tick), 0);
    cycles(1);
    check("s5_tick_e3", int'(tick), 1);
    check("s5_raw_e3", int'(level_raw), 129);
    set_in(0, 1, 0, 0);
    cycles(1);
    check("s5_tick_forced0", int'(tick), 0);
    check("s5_raw_hold", int'(level_raw), 129);

    // reset mid-operation near saturation
    do_reset(1, 1, 0, 1);
    cycles(30 * 8);
    set_in(1, 1, 0, 0);
    cycles(16);
    check("s6_raw_250", int'(level_raw), 250);
    check("s6_level_250", int'(level), 3);
    cycles(3);
    do_reset(1, 1, 0, 0);
    cycles(7);
    check("s6_no_tick_c7", int'(tick), 0);
    cycles(1);
    check("s6_tick_c8", int'(tick), 1);
    check("s6_raw_c8", int'(level_raw), 129);
    cycles(4);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
